// File: rtl/fir_result_serializer.sv
// Ping-pong buffer for FIR result blocks, streamed out one rounded/saturated
// 16-bit sample per valid/ready transfer.
module fir_result_serializer #(
  parameter int SAMPLES_NUM = 4,
  parameter int OUT_SHIFT   = 15
) (
  input  logic                     clkIn,
  input  logic                     resetIn,
  input  logic                     doneIn,
  input  logic [32*SAMPLES_NUM-1:0] dataIn,
  output logic                     readyOut,
  output logic                     validOut,
  input  logic                     readyIn,
  output logic [15:0]              dataOut,
  output logic                     lastOut,
  output logic                     overflowOut,
  output logic [7:0]               dropCountOut
);

  localparam int BW = 32 * SAMPLES_NUM;
  localparam int IW = (SAMPLES_NUM > 1) ? $clog2(SAMPLES_NUM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES_NUM - 1);
  localparam logic [32:0] RND = 33'(1) << (OUT_SHIFT - 1);

  // Handshake: a sample moves on any rising edge where validOut && readyIn;
  // while validOut && !readyIn the output register is frozen.

  logic [BW-1:0] slot_q [2];
  logic [1:0]    full_q;
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [IW-1:0] idx_q;

  logic          head_full;
  logic          load;
  logic          head_done;
  logic          accept;
  logic          drop;
  logic [31:0]   head_sample;
  logic [1:0]    full_next;

  function automatic logic [15:0] convert(input logic [31:0] x);
    logic signed [32:0] s;
    logic signed [32:0] r;
    s = $signed({x[31], x} + RND);
    r = s >>> OUT_SHIFT;
    if (r > 33'sd32767)
      convert = 16'h7fff;
    else if (r < -33'sd32768)
      convert = 16'h8000;
    else
      convert = r[15:0];
  endfunction

  // readyOut comes from the flag registers only.
  assign readyOut = ~&full_q;

  always_comb begin
    head_full   = full_q[rd_ptr_q];
    load        = (!validOut || readyIn) && head_full;
    head_done   = load && (idx_q == LAST_IDX);
    // A full buffer still accepts when the head slot is freed on this edge;
    // in that case the write pointer equals the read pointer.
    accept      = doneIn && (!(&full_q) || head_done);
    drop        = doneIn && !accept;
    head_sample = '0;
    for (int k = 0; k < SAMPLES_NUM; k++) begin
      if (idx_q == IW'(k))
        head_sample = slot_q[rd_ptr_q][BW-1-32*k -: 32];
    end
    full_next = full_q;
    if (head_done)
      full_next[rd_ptr_q] = 1'b0;
    if (accept)
      full_next[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clkIn) begin
    if (accept)
      slot_q[wr_ptr_q] <= dataIn;
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      full_q       <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      idx_q        <= '0;
      validOut     <= 1'b0;
      lastOut      <= 1'b0;
      dataOut      <= '0;
      overflowOut  <= 1'b0;
      dropCountOut <= '0;
    end else begin
      full_q <= full_next;
      if (accept)
        wr_ptr_q <= ~wr_ptr_q;
      if (head_done)
        rd_ptr_q <= ~rd_ptr_q;
      if (load) begin
        dataOut  <= convert(head_sample);
        validOut <= 1'b1;
        lastOut  <= (idx_q == LAST_IDX);
        idx_q    <= head_done ? '0 : idx_q + IW'(1);
      end else if (readyIn) begin
        validOut <= 1'b0;
        lastOut  <= 1'b0;
      end
      if (drop) begin
        overflowOut <= 1'b1;
        if (dropCountOut != 8'hff)
          dropCountOut <= dropCountOut + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fir_result_serializer.sv
// Directed bench for fir_result_serializer: latency, backpressure, fill/drop,
// simultaneous free+capture, asynchronous reset and drop-count saturation.
module tb_fir_result_serializer;

  logic         clkIn = 1'b0;
  logic         resetIn;
  logic         doneIn;
  logic [127:0] dataIn;
  logic         readyOut;
  logic         validOut;
  logic         readyIn;
  logic [15:0]  dataOut;
  logic         lastOut;
  logic         overflowOut;
  logic [7:0]   dropCountOut;

  fir_result_serializer #(.SAMPLES_NUM(4), .OUT_SHIFT(15)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .doneIn(doneIn), .dataIn(dataIn),
    .readyOut(readyOut), .validOut(validOut), .readyIn(readyIn),
    .dataOut(dataOut), .lastOut(lastOut), .overflowOut(overflowOut),
    .dropCountOut(dropCountOut)
  );

  always #5 clkIn = ~clkIn;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];

  // Blocks (slot 0 in the top lane) and their hand-computed outputs.
  localparam logic [127:0] BLK_A = {32'h00004000, 32'h3fffffff, 32'h80000000, 32'hffffc000};
  localparam logic [63:0]  OUT_A = {16'h0001, 16'h7fff, 16'h8000, 16'h0000};
  localparam logic [127:0] BLK_B = {32'h00010000, 32'hffff8000, 32'h3fff8000, 32'hc0000000};
  localparam logic [63:0]  OUT_B = {16'h0002, 16'hffff, 16'h7fff, 16'h8000};
  localparam logic [127:0] BLK_C = {32'h00000000, 32'h00003fff, 32'hffffbfff, 32'h00c00000};
  localparam logic [63:0]  OUT_C = {16'h0000, 16'h0000, 16'hffff, 16'h0180};
  localparam logic [127:0] BLK_D = {32'h7fffffff, 32'h00004000, 32'hffffffff, 32'h00014000};
  localparam logic [63:0]  OUT_D = {16'h7fff, 16'h0001, 16'h0000, 16'h0003};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] outs);
    for (int k = 0; k < 4; k++)
      exp_q.push_back({(k == 3), outs[63-16*k -: 16]});
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    resetIn = 1'b1;
    @(negedge clkIn);
    @(negedge clkIn);
    resetIn = 1'b0;
    @(negedge clkIn);
  endtask

  task automatic pulse(input logic [127:0] blk);
    doneIn = 1'b1;
    dataIn = blk;
    @(negedge clkIn);
    doneIn = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int waited = 0;
    while (!validOut && waited < budget) begin
      @(negedge clkIn);
      waited++;
    end
    check({tag, "_valid_timeout"}, validOut, 1'b1);
  endtask

  // One transfer cycle with readyIn high; the sample must be present.
  task automatic collect_one(input string tag);
    logic [16:0] e;
    check({tag, "_valid"}, validOut, 1'b1);
    if (validOut) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected_sample"}, dataOut, 32'hdead);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_data"}, dataOut, e[15:0]);
        check({tag, "_last"}, lastOut, e[16]);
      end
    end
    @(negedge clkIn);
  endtask

  task automatic drain(input string tag, input int budget);
    int waited = 0;
    logic [16:0] e;
    readyIn = 1'b1;
    while (exp_q.size() > 0 && waited < budget) begin
      if (validOut) begin
        e = exp_q.pop_front();
        check({tag, "_data"}, dataOut, e[15:0]);
        check({tag, "_last"}, lastOut, e[16]);
      end
      @(negedge clkIn);
      waited++;
    end
    check({tag, "_left_in_queue"}, exp_q.size(), 0);
    check({tag, "_idle_after"}, validOut, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetIn = 1'b1;
    doneIn  = 1'b0;
    readyIn = 1'b0;
    dataIn  = '0;
    @(negedge clkIn);
    @(negedge clkIn);
    check("rst_valid", validOut, 1'b0);
    check("rst_data", dataOut, 16'h0000);
    check("rst_last", lastOut, 1'b0);
    check("rst_overflow", overflowOut, 1'b0);
    check("rst_drops", dropCountOut, 8'd0);
    check("rst_ready", readyOut, 1'b1);
    resetIn = 1'b0;
    @(negedge clkIn);
    check("post_rst_ready", readyOut, 1'b1);

    // Streaming: first sample after edge t+1, then one per cycle.
    readyIn = 1'b1;
    push_exp(OUT_A);
    pulse(BLK_A);
    check("a_no_same_edge_load", validOut, 1'b0);
    @(negedge clkIn);
    for (int k = 0; k < 4; k++) collect_one("a_stream");
    check("a_idle_after", validOut, 1'b0);

    // Backpressure holds the first sample.
    readyIn = 1'b0;
    pulse(BLK_A);
    wait_valid("bp", 10);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", validOut, 1'b1);
      check("bp_hold_data", dataOut, 16'h0001);
      check("bp_hold_last", lastOut, 1'b0);
      @(negedge clkIn);
    end
    push_exp(OUT_A);
    drain("bp", 20);

    // Fill both slots, third block is dropped.
    readyIn = 1'b0;
    pulse(BLK_B);
    @(negedge clkIn);
    @(negedge clkIn);
    check("fill_ready_one_full", readyOut, 1'b1);
    pulse(BLK_C);
    check("fill_ready_both_full", readyOut, 1'b0);
    check("fill_no_overflow_yet", overflowOut, 1'b0);
    pulse(BLK_D);
    check("fill_overflow", overflowOut, 1'b1);
    check("fill_drops", dropCountOut, 8'd1);
    push_exp(OUT_B);
    push_exp(OUT_C);
    drain("fill", 40);
    check("fill_ready_after", readyOut, 1'b1);

    // Capture on the same edge that loads the head block's last sample.
    do_reset();
    readyIn = 1'b0;
    pulse(BLK_B);
    pulse(BLK_C);
    wait_valid("sim", 10);
    push_exp(OUT_B);
    push_exp(OUT_C);
    push_exp(OUT_D);
    readyIn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) begin
        check("sim_full_at_capture", readyOut, 1'b0);
        doneIn = 1'b1;
        dataIn = BLK_D;
      end else begin
        doneIn = 1'b0;
      end
      collect_one("sim");
    end
    doneIn = 1'b0;
    check("sim_idle_after", validOut, 1'b0);
    check("sim_overflow", overflowOut, 1'b0);
    check("sim_drops", dropCountOut, 8'd0);
    check("sim_left_in_queue", exp_q.size(), 0);
    exp_q.delete();

    // Asynchronous reset mid-block.
    readyIn = 1'b0;
    pulse(BLK_A);
    pulse(BLK_B);
    pulse(BLK_C);
    check("mid_overflow_before", overflowOut, 1'b1);
    readyIn = 1'b1;
    @(negedge clkIn);
    readyIn = 1'b0;
    check("mid_sample1_valid", validOut, 1'b1);
    check("mid_sample1_data", dataOut, 16'h7fff);
    #2 resetIn = 1'b1;
    #1;
    check("mid_rst_valid", validOut, 1'b0);
    check("mid_rst_data", dataOut, 16'h0000);
    check("mid_rst_last", lastOut, 1'b0);
    check("mid_rst_overflow", overflowOut, 1'b0);
    check("mid_rst_drops", dropCountOut, 8'd0);
    check("mid_rst_ready", readyOut, 1'b1);
    @(negedge clkIn);
    resetIn = 1'b0;
    readyIn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("mid_no_stale", validOut, 1'b0);
      @(negedge clkIn);
    end
    push_exp(OUT_C);
    pulse(BLK_C);
    drain("mid_after", 20);

    // Drop counter saturation.
    readyIn = 1'b0;
    pulse(BLK_A);
    pulse(BLK_B);
    for (int i = 0; i < 300; i++) begin
      doneIn = 1'b1;
      dataIn = BLK_C;
      @(negedge clkIn);
      if (i == 9)   check("sat_drops_10", dropCountOut, 8'd10);
      if (i == 253) check("sat_drops_254", dropCountOut, 8'd254);
    end
    doneIn = 1'b0;
    @(negedge clkIn);
    check("sat_drops_255", dropCountOut, 8'd255);
    check("sat_overflow", overflowOut, 1'b1);
    check("sat_ready", readyOut, 1'b0);
    push_exp(OUT_A);
    push_exp(OUT_B);
    drain("sat_drain", 40);
    check("sat_drops_held", dropCountOut, 8'd255);
    do_reset();
    check("final_rst_drops", dropCountOut, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_result_serializer.md
Name: fir_result_serializer

Overview:
- Downstream stage of the block FIR filter. Captures each completed block of SAMPLES_NUM 32-bit saturated results on the filter's done pulse.
- Buffers up to two blocks in ping-pong slots and emits them one sample per transfer on a valid/ready stream.
- Each emitted sample is rounded, shifted and saturated to a 16-bit signed output.
- Drives readyOut, which the filter controller uses to gate its start.

Parameters:
- SAMPLES_NUM, 4, results per block (1..8); must match the filter.
- OUT_SHIFT, 15, arithmetic right shift applied to each 32-bit result (1..16).

Ports:
- clkIn  input  1  clock; all state updates on the rising edge
- resetIn  input  1  asynchronous, active-high reset
- doneIn  input  1  one-cycle pulse from the filter; dataIn is valid in the same cycle
- dataIn  input  32*SAMPLES_NUM  results block; slot 0 in bits [32*SAMPLES_NUM-1 -: 32], slot k at descending 32-bit lanes
- readyOut  output  1  1 when at least one block slot is free; upstream starts the filter only while it is high
- validOut  output  1  dataOut holds a sample
- readyIn  input  1  consumer accepts the sample; a transfer occurs on a cycle with validOut && readyIn
- dataOut  output  16  signed output sample
- lastOut  output  1  qualifies dataOut as the final sample (slot SAMPLES_NUM-1) of its block
- overflowOut  output  1  sticky; set when a block is dropped, cleared only by reset
- dropCountOut  output  8  count of dropped blocks, saturating at 255

Behaviour:
- Reset, asynchronous and active-high. It clears:
  - both slot-full flags, the write and read slot pointers, and the sample index;
  - validOut, lastOut, dataOut (to 0), overflowOut and dropCountOut.
- readyOut is 1 while reset is applied and after reset.
- Reset in the middle of a block discards all buffered data. No partial output follows reset.
- Storage: two slots of 32*SAMPLES_NUM bits, each with a full flag.
  - fullCount = number of set flags.
  - readyOut = (fullCount < 2), decoded from registers only, with no combinational path from doneIn or readyIn.
- Capture: on a rising edge with doneIn=1, dataIn is written to the write-pointer slot. The slot's flag is set and the write pointer toggles.
  - The block is accepted if fullCount < 2.
  - It is also accepted if fullCount == 2 and the head slot's last sample is loaded into the output register on the same edge (the freed slot is reused).
  - Otherwise the block is dropped: slots are unchanged, overflowOut goes to 1, and dropCountOut increments (holds at 255).
- Output register load condition: (!validOut || readyIn) && head slot full.
  - On load, dataOut is the conversion of sample[index] of the head slot, validOut=1, and lastOut=(index == SAMPLES_NUM-1).
  - index then increments. When index wraps from SAMPLES_NUM-1 to 0, the head flag clears and the read pointer toggles.
  - If the load condition is false and readyIn=1, validOut goes to 0.
  - While validOut && !readyIn, dataOut, lastOut and validOut are held stable.
- Latency:
  - doneIn at edge t into an empty buffer with an idle output gives validOut=1 with slot 0 after edge t+1.
  - With readyIn held at 1, one sample is emitted per cycle and blocks stream back to back with no bubble.
- Conversion, applied per sample x (signed 32):
  - s = sign-extend(x) to 33 bits, plus 2^(OUT_SHIFT-1).
  - r = s >>> OUT_SHIFT (arithmetic), giving round-half-up.
  - If r > 32767, output 0x7FFF. If r < -32768, output 0x8000. Otherwise output r[15:0].
- Slot order: within a block, slot 0 (MSB lane) is emitted first and slot SAMPLES_NUM-1 last. Blocks are emitted in capture order.
- Capture and read operate on different slots in the same cycle without interference. A capture into an empty buffer does not load the output register on that same edge.

Test Plan:
- Block {0x00004000, 0x3FFFFFFF, 0x80000000, 0xFFFFC000} with readyIn=1:
  - Outputs, one per cycle starting at edge t+1: 0x0001, 0x7FFF, 0x8000, 0x0000.
  - lastOut is asserted only with 0x0000.
- Backpressure: same block with readyIn=0 for 5 cycles after validOut rises:
  - dataOut stays 0x0001 and validOut stays 1.
  - After readyIn rises, the full sequence follows with no sample lost or duplicated.
- Fill: two doneIn pulses 3 cycles apart with readyIn=0:
  - readyOut falls after the second capture.
  - A third doneIn gives overflowOut=1 and dropCountOut=1.
  - Output with readyIn=1 afterwards is exactly blocks 1 then 2.
- Simultaneous free and capture: both slots full, readyIn=1. doneIn coincides with the edge that loads block 1's last sample:
  - The new block is accepted and overflowOut stays 0.
  - Blocks 2 then 3 follow contiguously.
- Reset mid-stream: assert resetIn while block sample 1 is on dataOut:
  - validOut, dataOut and lastOut go to 0 immediately (asynchronously), and overflowOut and dropCountOut go to 0.
  - readyOut=1.
  - No stale samples appear after release.
- Drop counter saturation: 300 doneIn pulses into a full buffer with readyIn=0 -> dropCountOut=255 and overflowOut=1.
